// File: rtl/detector_avalon_arbiter_if.sv
// Bus bundle for the two-port detector register arbiter: two Avalon-MM requester
// ports, port 1's lock request, and the shared register-slave port.
interface detector_avalon_arbiter_if #(
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] s0_address;
    logic                  s0_read;
    logic                  s0_write;
    logic [31:0]           s0_writedata;
    logic                  s0_waitrequest;
    logic [31:0]           s0_readdata;
    logic                  s0_readdatavalid;

    logic [ADDR_WIDTH-1:0] s1_address;
    logic                  s1_read;
    logic                  s1_write;
    logic [31:0]           s1_writedata;
    logic                  s1_waitrequest;
    logic [31:0]           s1_readdata;
    logic                  s1_readdatavalid;
    logic                  s1_lock;

    logic [ADDR_WIDTH-1:0] m_address;
    logic                  m_read;
    logic                  m_write;
    logic [31:0]           m_writedata;
    logic [31:0]           m_readdata;

    // The arbiter is the Avalon slave of both requesters; the master view is the
    // requesters plus the register bank that answers on m_readdata.
    modport slave (
        input  s0_address, s0_read, s0_write, s0_writedata,
        output s0_waitrequest, s0_readdata, s0_readdatavalid,
        input  s1_address, s1_read, s1_write, s1_writedata, s1_lock,
        output s1_waitrequest, s1_readdata, s1_readdatavalid,
        output m_address, m_read, m_write, m_writedata,
        input  m_readdata
    );

    modport master (
        output s0_address, s0_read, s0_write, s0_writedata,
        input  s0_waitrequest, s0_readdata, s0_readdatavalid,
        output s1_address, s1_read, s1_write, s1_writedata, s1_lock,
        input  s1_waitrequest, s1_readdata, s1_readdatavalid,
        input  m_address, m_read, m_write, m_writedata,
        output m_readdata
    );
endinterface

// File: rtl/detector_avalon_arbiter.sv
// Round-robin arbiter sharing one detector register slave between the host CPU
// (port 0) and the frame sequencer (port 1), with a port-1 bus lock.
module detector_avalon_arbiter #(
    parameter int ADDR_WIDTH = 4
) (
    input logic                      clk,
    input logic                      rst,
    detector_avalon_arbiter_if.slave bus
);
    localparam logic [0:0] ST_RR     = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]            state;
    logic                  last_grant;   // port id of the most recent acceptance
    logic                  req0;
    logic                  req1;
    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [31:0]           sel_writedata;
    logic                  sel_read;
    logic                  sel_write;
    logic                  tag_valid;
    logic                  tag_port;

    assign req0 = bus.s0_read | bus.s0_write;
    assign req1 = bus.s1_read | bus.s1_write;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else chain can infer a latch.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (state == ST_LOCKED) begin
                grant1 = req1;
            end else if (req0 && req1) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    assign bus.s0_waitrequest = rst | (state == ST_LOCKED) | (req0 & ~grant0);
    assign bus.s1_waitrequest = rst | (req1 & ~grant1);

    // A simultaneous read and write is issued as a write only.
    assign accept        = grant0 | grant1;
    assign sel_address   = grant1 ? bus.s1_address   : bus.s0_address;
    assign sel_writedata = grant1 ? bus.s1_writedata : bus.s0_writedata;
    assign sel_write     = grant1 ? bus.s1_write     : bus.s0_write;
    assign sel_read      = grant1 ? (bus.s1_read & ~bus.s1_write)
                                  : (bus.s0_read & ~bus.s0_write);

    // NOTE: sequential state is assigned with non-blocking (<=) so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= ST_RR;
            last_grant           <= 1'b1;
            bus.m_address        <= '0;
            bus.m_writedata      <= '0;
            bus.m_read           <= 1'b0;
            bus.m_write          <= 1'b0;
            tag_valid            <= 1'b0;
            tag_port             <= 1'b0;
            bus.s0_readdatavalid <= 1'b0;
            bus.s1_readdatavalid <= 1'b0;
        end else begin
            bus.m_read  <= accept & sel_read;
            bus.m_write <= accept & sel_write;
            if (accept) begin
                bus.m_address   <= sel_address;
                bus.m_writedata <= sel_writedata;
                last_grant      <= grant1;
            end

            // Owner tag rides alongside m_read, then qualifies the returning data.
            tag_valid            <= accept & sel_read;
            tag_port             <= grant1;
            bus.s0_readdatavalid <= tag_valid & ~tag_port;
            bus.s1_readdatavalid <= tag_valid & tag_port;

            case (state)
                ST_RR:     if (grant1 && bus.s1_lock) state <= ST_LOCKED;
                ST_LOCKED: if (!bus.s1_lock) state <= ST_RR;
                default:   state <= ST_RR;
            endcase
        end
    end

    assign bus.s0_readdata = bus.m_readdata;
    assign bus.s1_readdata = bus.m_readdata;
endmodule

// File: tb/tb_detector_avalon_arbiter.sv
// Bench for detector_avalon_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level model of the arbitration rules.
module tb_detector_avalon_arbiter;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    detector_avalon_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
    detector_avalon_arbiter #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Register bank behind the arbiter: writes land on the strobe edge, reads answer next cycle.
    logic [31:0] slave_mem [16];
    always @(posedge clk) begin
        if (bus.m_write) slave_mem[bus.m_address] <= bus.m_writedata;
        if (bus.m_read) bus.m_readdata <= slave_mem[bus.m_address];
    end

    int passed = 0;
    int total  = 0;
    int cycle  = 0;

    // Reference model: lock flag, last winner, memory image and a queue of due read returns.
    typedef struct { int due; int port; logic [31:0] data; } rd_t;
    rd_t         pend[$];
    bit          ref_locked = 1'b0;
    int          ref_last = 1;
    logic [31:0] ref_mem [16];
    logic          exp_m_read = 0, exp_m_write = 0, exp_rdv0 = 0, exp_rdv1 = 0;
    logic [AW-1:0] exp_m_addr = '0;
    logic [31:0]   exp_m_wdata = '0, exp_rdata = '0;
    logic          e_w0, e_w1, e_acc0, e_acc1;

    task automatic model_eval();
        bit r0, r1;
        r0 = bus.s0_read || bus.s0_write;
        r1 = bus.s1_read || bus.s1_write;
        e_acc0 = 0; e_acc1 = 0;
        if (rst) begin
            e_w0 = 1; e_w1 = 1;
            return;
        end
        if (ref_locked) e_acc1 = r1;
        else if (r0 && r1) begin e_acc0 = (ref_last != 0); e_acc1 = (ref_last == 0); end
        else begin e_acc0 = r0; e_acc1 = r1; end
        e_w0 = ref_locked || (r0 && !e_acc0);
        e_w1 = r1 && !e_acc1;
    endtask

    task automatic model_commit();
        int p; bit rd, wr; logic [AW-1:0] a; logic [31:0] d;
        cycle++;
        if (rst) begin
            ref_locked = 0; ref_last = 1;
            exp_m_read = 0; exp_m_write = 0; exp_m_addr = '0; exp_m_wdata = '0;
            exp_rdv0 = 0; exp_rdv1 = 0;
            pend.delete();
            return;
        end
        exp_m_read = 0; exp_m_write = 0;
        if (e_acc0 || e_acc1) begin
            p  = e_acc1 ? 1 : 0;
            rd = p ? bus.s1_read : bus.s0_read;
            wr = p ? bus.s1_write : bus.s0_write;
            a  = p ? bus.s1_address : bus.s0_address;
            d  = p ? bus.s1_writedata : bus.s0_writedata;
            exp_m_addr = a; exp_m_wdata = d; exp_m_write = wr; exp_m_read = rd && !wr;
            if (wr) ref_mem[a] = d;
            else pend.push_back('{due: cycle + 1, port: p, data: ref_mem[a]});
            ref_last = p;
        end
        ref_locked = ref_locked ? bus.s1_lock : (e_acc1 && bus.s1_lock);
        exp_rdv0 = 0; exp_rdv1 = 0;
        if (pend.size() > 0 && pend[0].due == cycle) begin
            exp_rdv0 = (pend[0].port == 0);
            exp_rdv1 = (pend[0].port == 1);
            exp_rdata = pend[0].data;
            void'(pend.pop_front());
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_port(input int p, input bit rd, input bit wr,
                            input logic [AW-1:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus.s0_read = rd; bus.s0_write = wr; bus.s0_address = a; bus.s0_writedata = d;
        end else begin
            bus.s1_read = rd; bus.s1_write = wr; bus.s1_address = a; bus.s1_writedata = d;
        end
    endtask

    task automatic idle();
        set_port(0, 0, 0, '0, '0);
        set_port(1, 0, 0, '0, '0);
    endtask

    task automatic test_reset();
        rst = 1;
        set_port(0, 1, 0, 4'h1, '0);
        set_port(1, 0, 1, 4'h2, 32'h55);
        #2;
        total++; if (bus.s0_waitrequest !== 1'b1) $display("FAIL reset_wait0: got %b want 1", bus.s0_waitrequest); else passed++;
        total++; if (bus.s1_waitrequest !== 1'b1) $display("FAIL reset_wait1: got %b want 1", bus.s1_waitrequest); else passed++;
        tick(); tick();
        #2;
        total++; if (bus.m_read !== 1'b0 || bus.m_write !== 1'b0) $display("FAIL reset_strobes: got r%b w%b want 0 0", bus.m_read, bus.m_write); else passed++;
        total++; if (bus.m_address !== 4'h0 || bus.m_writedata !== 32'h0) $display("FAIL reset_mbus: got %h/%h want 0/0", bus.m_address, bus.m_writedata); else passed++;
        total++; if (bus.s0_readdatavalid !== 1'b0 || bus.s1_readdatavalid !== 1'b0) $display("FAIL reset_rdv: got %b%b want 00", bus.s0_readdatavalid, bus.s1_readdatavalid); else passed++;
        rst = 0;
        idle();
        #2;
        total++; if (bus.s0_waitrequest !== 1'b0 || bus.s1_waitrequest !== 1'b0) $display("FAIL idle_wait: got %b%b want 00", bus.s0_waitrequest, bus.s1_waitrequest); else passed++;
        tick();
    endtask

    task automatic test_write_readback();
        set_port(0, 0, 1, 4'h2, 32'hDEADBEEF);
        #2;
        total++; if (bus.s0_waitrequest !== 1'b0) $display("FAIL wr_wait0: got %b want 0", bus.s0_waitrequest); else passed++;
        tick(); idle(); #2;
        total++; if (bus.m_write !== 1'b1 || bus.m_read !== 1'b0) $display("FAIL wr_strobe: got w%b r%b want w1 r0", bus.m_write, bus.m_read); else passed++;
        total++; if (bus.m_address !== 4'h2 || bus.m_writedata !== 32'hDEADBEEF) $display("FAIL wr_mbus: got %h/%h want 2/deadbeef", bus.m_address, bus.m_writedata); else passed++;
        tick(); #2;
        total++; if (bus.m_write !== 1'b0) $display("FAIL wr_single: got %b want 0", bus.m_write); else passed++;
        set_port(0, 1, 0, 4'h2, '0);
        #2;
        total++; if (bus.s0_waitrequest !== 1'b0) $display("FAIL rd_wait0: got %b want 0", bus.s0_waitrequest); else passed++;
        tick(); idle(); #2;
        total++; if (bus.m_read !== 1'b1 || bus.m_address !== 4'h2) $display("FAIL rd_strobe: got r%b a%h want r1 a2", bus.m_read, bus.m_address); else passed++;
        tick(); #2;
        total++; if (bus.s0_readdatavalid !== 1'b1 || bus.s0_readdata !== 32'hDEADBEEF) $display("FAIL rd_return: got v%b %h want v1 deadbeef", bus.s0_readdatavalid, bus.s0_readdata); else passed++;
        total++; if (bus.s1_readdatavalid !== 1'b0) $display("FAIL rd_other_port: got %b want 0", bus.s1_readdatavalid); else passed++;
        tick();
    endtask

    task automatic test_read_write_both();
        set_port(0, 1, 1, 4'h7, 32'h12);
        #2;
        total++; if (bus.s0_waitrequest !== 1'b0) $display("FAIL rw_wait0: got %b want 0", bus.s0_waitrequest); else passed++;
        tick(); idle(); #2;
        total++; if (bus.m_write !== 1'b1 || bus.m_read !== 1'b0 || bus.m_address !== 4'h7) $display("FAIL rw_strobe: got w%b r%b a%h want w1 r0 a7", bus.m_write, bus.m_read, bus.m_address); else passed++;
        tick(); #2;
        total++; if (bus.s0_readdatavalid !== 1'b0 || bus.m_write !== 1'b0) $display("FAIL rw_quiet1: got v%b w%b want 0 0", bus.s0_readdatavalid, bus.m_write); else passed++;
        tick(); #2;
        total++; if (bus.s0_readdatavalid !== 1'b0 || bus.s1_readdatavalid !== 1'b0) $display("FAIL rw_no_rdv: got %b%b want 00", bus.s0_readdatavalid, bus.s1_readdatavalid); else passed++;
        tick();
    endtask

    task automatic test_alternate();
        set_port(0, 0, 1, 4'h1, 32'h1111_0001);
        tick(); idle();
        set_port(1, 0, 1, 4'h3, 32'h3333_0003);
        tick(); idle();
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                set_port(0, 1, 0, 4'h1, '0);
                set_port(1, 1, 0, 4'h3, '0);
            end else idle();
            #2;
            if (i < 8) begin
                total++; if (bus.s0_waitrequest !== logic'(i % 2 == 1) || bus.s1_waitrequest !== logic'(i % 2 == 0))
                    $display("FAIL alt_grant[%0d]: got wait %b%b want %b%b", i, bus.s0_waitrequest, bus.s1_waitrequest, i % 2 == 1, i % 2 == 0); else passed++;
            end
            if (i >= 1 && i <= 8) begin
                total++; if (bus.m_read !== 1'b1 || bus.m_address !== ((i - 1) % 2 == 1 ? 4'h3 : 4'h1))
                    $display("FAIL alt_mread[%0d]: got r%b a%h", i, bus.m_read, bus.m_address); else passed++;
            end
            if (i >= 2) begin
                total++; if (bus.s0_readdatavalid !== logic'(i % 2 == 0) || bus.s1_readdatavalid !== logic'(i % 2 == 1) ||
                             bus.s0_readdata !== (i % 2 == 0 ? 32'h1111_0001 : 32'h3333_0003))
                    $display("FAIL alt_return[%0d]: got v%b%b d%h", i, bus.s0_readdatavalid, bus.s1_readdatavalid, bus.s0_readdata); else passed++;
            end
            tick();
        end
    endtask

    task automatic test_lock();
        bus.s1_lock = 1;
        set_port(1, 0, 1, 4'h4, 32'hA4);
        #2;
        total++; if (bus.s1_waitrequest !== 1'b0) $display("FAIL lock_enter: got %b want 0", bus.s1_waitrequest); else passed++;
        tick();
        for (int i = 0; i < 2; i++) begin
            set_port(1, 0, 1, AW'(5 + i), 32'hA5 + i);
            set_port(0, 0, 1, 4'h8, 32'hA8);
            #2;
            total++; if (bus.s0_waitrequest !== 1'b1 || bus.s1_waitrequest !== 1'b0) $display("FAIL lock_hold[%0d]: got wait %b%b want 10", i, bus.s0_waitrequest, bus.s1_waitrequest); else passed++;
            total++; if (bus.m_write !== 1'b1 || bus.m_address !== AW'(4 + i)) $display("FAIL lock_mwr[%0d]: got w%b a%h", i, bus.m_write, bus.m_address); else passed++;
            tick();
        end
        set_port(1, 0, 0, '0, '0);
        bus.s1_lock = 0;
        #2;
        total++; if (bus.s0_waitrequest !== 1'b1 || bus.m_address !== 4'h6) $display("FAIL lock_drop: got wait %b a%h want 1 6", bus.s0_waitrequest, bus.m_address); else passed++;
        tick(); #2;
        total++; if (bus.s0_waitrequest !== 1'b0) $display("FAIL lock_exit: got %b want 0", bus.s0_waitrequest); else passed++;
        tick(); idle(); #2;
        total++; if (bus.m_write !== 1'b1 || bus.m_address !== 4'h8 || bus.m_writedata !== 32'hA8) $display("FAIL lock_p0_issue: got w%b a%h d%h", bus.m_write, bus.m_address, bus.m_writedata); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_read();
        bus.s1_lock = 1;
        set_port(1, 1, 0, 4'h3, '0);
        #2;
        total++; if (bus.s1_waitrequest !== 1'b0) $display("FAIL rstrd_accept: got %b want 0", bus.s1_waitrequest); else passed++;
        tick(); idle(); rst = 1; #2;
        total++; if (bus.s0_waitrequest !== 1'b1 || bus.s1_waitrequest !== 1'b1) $display("FAIL rstrd_wait: got %b%b want 11", bus.s0_waitrequest, bus.s1_waitrequest); else passed++;
        tick(); rst = 0;
        set_port(0, 0, 1, 4'h9, 32'h99);
        #2;
        total++; if (bus.m_read !== 1'b0 || bus.s1_readdatavalid !== 1'b0) $display("FAIL rstrd_flush: got r%b v%b want 0 0", bus.m_read, bus.s1_readdatavalid); else passed++;
        total++; if (bus.s0_waitrequest !== 1'b0) $display("FAIL rstrd_state_rr: got %b want 0", bus.s0_waitrequest); else passed++;
        tick(); idle(); bus.s1_lock = 0; #2;
        total++; if (bus.s1_readdatavalid !== 1'b0 || bus.s0_readdatavalid !== 1'b0 || bus.m_write !== 1'b1) $display("FAIL rstrd_after: got v%b%b w%b", bus.s0_readdatavalid, bus.s1_readdatavalid, bus.m_write); else passed++;
        tick();
    endtask

    task automatic test_lock_no_request();
        bus.s1_lock = 1;
        for (int i = 0; i < 3; i++) begin
            set_port(0, 0, 1, AW'(10 + i), $urandom);
            #2;
            total++; if (bus.s0_waitrequest !== 1'b0) $display("FAIL nolock_wait0[%0d]: got %b want 0", i, bus.s0_waitrequest); else passed++;
            if (i > 0) begin
                total++; if (bus.m_write !== 1'b1 || bus.m_address !== AW'(9 + i)) $display("FAIL nolock_mwr[%0d]: got w%b a%h", i, bus.m_write, bus.m_address); else passed++;
            end
            tick();
        end
        idle(); bus.s1_lock = 0;
        tick();
    endtask

    task automatic test_random();
        bit hold0 = 0, hold1 = 0;
        for (int n = 0; n < 600; n++) begin
            if (!hold0) set_port(0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), $urandom);
            if (!hold1) set_port(1, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), $urandom);
            bus.s1_lock = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 63) == 0);
            #2;
            model_eval();
            total++; if (bus.s0_waitrequest !== e_w0) $display("FAIL rnd_wait0 @%0d: got %b want %b", cycle, bus.s0_waitrequest, e_w0); else passed++;
            total++; if (bus.s1_waitrequest !== e_w1) $display("FAIL rnd_wait1 @%0d: got %b want %b", cycle, bus.s1_waitrequest, e_w1); else passed++;
            total++; if (bus.m_read !== exp_m_read || bus.m_write !== exp_m_write) $display("FAIL rnd_strobe @%0d: got r%b w%b want r%b w%b", cycle, bus.m_read, bus.m_write, exp_m_read, exp_m_write); else passed++;
            total++; if (bus.m_address !== exp_m_addr) $display("FAIL rnd_maddr @%0d: got %h want %h", cycle, bus.m_address, exp_m_addr); else passed++;
            total++; if (bus.m_writedata !== exp_m_wdata) $display("FAIL rnd_mwdata @%0d: got %h want %h", cycle, bus.m_writedata, exp_m_wdata); else passed++;
            total++; if (bus.s0_readdatavalid !== exp_rdv0 || bus.s1_readdatavalid !== exp_rdv1) $display("FAIL rnd_rdv @%0d: got %b%b want %b%b", cycle, bus.s0_readdatavalid, bus.s1_readdatavalid, exp_rdv0, exp_rdv1); else passed++;
            if (exp_rdv0 || exp_rdv1) begin
                total++; if ((exp_rdv0 ? bus.s0_readdata : bus.s1_readdata) !== exp_rdata)
                    $display("FAIL rnd_rdata @%0d: got %h want %h", cycle, exp_rdv0 ? bus.s0_readdata : bus.s1_readdata, exp_rdata); else passed++;
            end
            hold0 = e_w0 && (bus.s0_read || bus.s0_write);
            hold1 = e_w1 && (bus.s1_read || bus.s1_write);
            tick();
        end
        rst = 0; idle(); bus.s1_lock = 0;
        repeat (3) tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = '0;
            ref_mem[i] = '0;
        end
        bus.m_readdata = '0;
        bus.s1_lock = 0;
        idle();
        rst = 1;
        #1;
        test_reset();
        test_write_readback();
        test_read_write_both();
        test_alternate();
        test_lock();
        test_reset_mid_read();
        test_lock_no_request();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
